// File: rtl/vga_pkg.sv
// Shared definitions for the character-VRAM text writer: screen geometry,
// control codes and the writer state enumeration.
package vga_pkg;

  localparam int COLS_DEF = 70;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    DRAIN,
    CLEAR
  } state_e;

endpackage

// File: rtl/text_scroller.sv
// Address sequencer for the scroll-up copy and bottom-row clear, plus the
// register that pairs each VRAM read with its delayed write one row higher.
module text_scroller
  import vga_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  state_e     state_i,
  input  logic       start_scroll_i,
  input  logic       start_clear_i,
  output logic       scroll_done_o,
  output logic       clear_done_o,
  output logic [6:0] rd_addr_h_o,
  output logic [4:0] rd_addr_v_o,
  input  logic [7:0] rd_data_i,
  output logic       wr_req_o,
  output logic [6:0] wr_addr_h_o,
  output logic [4:0] wr_addr_v_o,
  output logic [7:0] wr_data_o
);

  localparam logic [6:0] LastCol = 7'(COLS - 1);
  localparam logic [4:0] LastRow = 5'(ROWS - 1);

  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic       rdValid_q, rdValid_d;
  logic [6:0] rdH_q;
  logic [4:0] rdV_q;
  logic       atLastCol;

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    atLastCol     = (col_q == LastCol);
    scroll_done_o = (state_i == SCROLL) && atLastCol && (row_q == LastRow);
    clear_done_o  = (state_i == CLEAR) && atLastCol;
    rdValid_d     = (state_i == SCROLL);

    // Counters park on the final address instead of running past the screen.
    if (start_scroll_i) begin
      col_d = '0;
      row_d = 5'd1;
    end else if (start_clear_i) begin
      col_d = '0;
      row_d = LastRow;
    end else if ((state_i == SCROLL) && !scroll_done_o) begin
      if (atLastCol) begin
        col_d = '0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if ((state_i == CLEAR) && !atLastCol) begin
      col_d = col_q + 7'd1;
    end

    wr_req_o    = 1'b0;
    wr_addr_h_o = '0;
    wr_addr_v_o = '0;
    wr_data_o   = '0;
    if (rdValid_q) begin
      wr_req_o    = 1'b1;
      wr_addr_h_o = rdH_q;
      wr_addr_v_o = rdV_q - 5'd1;
      wr_data_o   = rd_data_i;
    end else if (state_i == CLEAR) begin
      wr_req_o    = 1'b1;
      wr_addr_h_o = col_q;
      wr_addr_v_o = LastRow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      rdValid_q <= 1'b0;
      rdH_q     <= '0;
      rdV_q     <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      rdValid_q <= rdValid_d;
      rdH_q     <= col_q;
      rdV_q     <= row_q;
    end
  end

  assign rd_addr_h_o = col_q;
  assign rd_addr_v_o = row_q;

endmodule

// File: rtl/text_writer.sv
// Terminal-style character writer: places incoming ASCII codes at the cursor
// in character VRAM, handling enter, backspace and scroll-up at the bottom row.
module text_writer
  import vga_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_ascii,
  output logic       in_ready,
  output logic       vwr_en,
  output logic [6:0] vwr_addr_h,
  output logic [4:0] vwr_addr_v,
  output logic [7:0] vwr_data,
  output logic [6:0] vrd_addr_h,
  output logic [4:0] vrd_addr_v,
  input  logic [7:0] vrd_data,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y
);

  localparam logic [6:0] LastCol = 7'(COLS - 1);
  localparam logic [4:0] LastRow = 5'(ROWS - 1);

  state_e     state_q, state_d;
  logic [6:0] curX_q, curX_d;
  logic [4:0] curY_q, curY_d;
  logic       wrEn_q, wrEn_d;
  logic [6:0] wrH_q, wrH_d;
  logic [4:0] wrV_q, wrV_d;
  logic [7:0] wrData_q, wrData_d;
  logic       accept, advance, startScroll, startClear;
  logic       scrollDone, clearDone, scWrReq;
  logic [6:0] scWrH;
  logic [4:0] scWrV;
  logic [7:0] scWrData;

  text_scroller #(.COLS(COLS), .ROWS(ROWS)) u_scroller (
    .clk           (clk),
    .rst           (rst),
    .state_i       (state_q),
    .start_scroll_i(startScroll),
    .start_clear_i (startClear),
    .scroll_done_o (scrollDone),
    .clear_done_o  (clearDone),
    .rd_addr_h_o   (vrd_addr_h),
    .rd_addr_v_o   (vrd_addr_v),
    .rd_data_i     (vrd_data),
    .wr_req_o      (scWrReq),
    .wr_addr_h_o   (scWrH),
    .wr_addr_v_o   (scWrV),
    .wr_data_o     (scWrData)
  );

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    curX_d      = curX_q;
    curY_d      = curY_q;
    wrEn_d      = 1'b0;
    wrH_d       = wrH_q;
    wrV_d       = wrV_q;
    wrData_d    = wrData_q;
    advance     = 1'b0;
    startScroll = 1'b0;
    startClear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_ascii == ASCII_CR) begin
            curX_d  = '0;
            advance = 1'b1;
          end else if (in_ascii == ASCII_BS) begin
            if (curX_q != '0) begin
              curX_d   = curX_q - 7'd1;
              wrEn_d   = 1'b1;
              wrH_d    = curX_q - 7'd1;
              wrV_d    = curY_q;
              wrData_d = 8'h00;
            end else if (curY_q != '0) begin
              curX_d   = LastCol;
              curY_d   = curY_q - 5'd1;
              wrEn_d   = 1'b1;
              wrH_d    = LastCol;
              wrV_d    = curY_q - 5'd1;
              wrData_d = 8'h00;
            end
          end else begin
            wrEn_d   = 1'b1;
            wrH_d    = curX_q;
            wrV_d    = curY_q;
            wrData_d = in_ascii;
            if (curX_q == LastCol) begin
              curX_d  = '0;
              advance = 1'b1;
            end else begin
              curX_d = curX_q + 7'd1;
            end
          end
          // On the bottom row the cursor stays put and the screen moves instead.
          if (advance) begin
            if (curY_q < LastRow) begin
              curY_d = curY_q + 5'd1;
            end else begin
              state_d     = SCROLL;
              startScroll = 1'b1;
            end
          end
        end
      end
      SCROLL: if (scrollDone) state_d = DRAIN;
      DRAIN: begin
        state_d    = CLEAR;
        startClear = 1'b1;
      end
      CLEAR: if (clearDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (scWrReq) begin
      wrEn_d   = 1'b1;
      wrH_d    = scWrH;
      wrV_d    = scWrV;
      wrData_d = scWrData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      curX_q   <= '0;
      curY_q   <= '0;
      wrEn_q   <= 1'b0;
      wrH_q    <= '0;
      wrV_q    <= '0;
      wrData_q <= '0;
    end else begin
      state_q  <= state_d;
      curX_q   <= curX_d;
      curY_q   <= curY_d;
      wrEn_q   <= wrEn_d;
      wrH_q    <= wrH_d;
      wrV_q    <= wrV_d;
      wrData_q <= wrData_d;
    end
  end

  assign vwr_en     = wrEn_q;
  assign vwr_addr_h = wrH_q;
  assign vwr_addr_v = wrV_q;
  assign vwr_data   = wrData_q;
  assign cur_x      = curX_q;
  assign cur_y      = curY_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer with a synchronous-read character VRAM model
// and hand-computed expectations for writes, cursor motion and scrolling.
module tb_text_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_ascii;
  logic       in_ready;
  logic       vwr_en;
  logic [6:0] vwr_addr_h;
  logic [4:0] vwr_addr_v;
  logic [7:0] vwr_data;
  logic [6:0] vrd_addr_h;
  logic [4:0] vrd_addr_v;
  logic [7:0] vrd_data;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  logic [7:0] vram [30][70];
  logic       preloadReq;
  int         compareCount = 0;
  int         failCount    = 0;
  int         writeCount   = 0;
  int         lastH = 0, lastV = 0;
  int         count42 = 0, h42 = -1, v42 = -1;

  text_writer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ascii  (in_ascii),
    .in_ready  (in_ready),
    .vwr_en    (vwr_en),
    .vwr_addr_h(vwr_addr_h),
    .vwr_addr_v(vwr_addr_v),
    .vwr_data  (vwr_data),
    .vrd_addr_h(vrd_addr_h),
    .vrd_addr_v(vrd_addr_v),
    .vrd_data  (vrd_data),
    .cur_x     (cur_x),
    .cur_y     (cur_y)
  );

  always #5 clk = ~clk;

  // Preload fills row r with value r in a single edge.
  always @(posedge clk) begin
    if (preloadReq) begin
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 70; c++)
          vram[r][c] <= 8'(r);
    end else if (vwr_en && vwr_addr_h < 7'd70 && vwr_addr_v < 5'd30) begin
      vram[vwr_addr_v][vwr_addr_h] <= vwr_data;
    end
    if (vrd_addr_h < 7'd70 && vrd_addr_v < 5'd30)
      vrd_data <= vram[vrd_addr_v][vrd_addr_h];
    else
      vrd_data <= 8'h00;
  end

  always @(posedge clk) begin
    if (vwr_en) begin
      writeCount++;
      lastH = int'(vwr_addr_h);
      lastV = int'(vwr_addr_v);
      if (vwr_data == 8'h42) begin
        count42++;
        h42 = int'(vwr_addr_h);
        v42 = int'(vwr_addr_v);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers a code until accepted; returns at the negedge of the cycle after acceptance.
  task automatic applyStimulus(input logic [7:0] code);
    int guard = 0;
    in_valid = 1'b1;
    in_ascii = code;
    while (!in_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int wc, lowCycles, badCells;
    rst = 1'b1;
    in_valid = 1'b0;
    in_ascii = 8'h00;
    preloadReq = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_cur_x", 32'(cur_x), 32'd0);
    checkOutput("reset_cur_y", 32'(cur_y), 32'd0);
    checkOutput("reset_vwr_en", 32'(vwr_en), 32'd0);
    checkOutput("reset_vwr_data", 32'(vwr_data), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

    $display("[TB] single printable code");
    applyStimulus(8'h41);
    checkOutput("A_vwr_en", 32'(vwr_en), 32'd1);
    checkOutput("A_vwr_data", 32'(vwr_data), 32'h41);
    checkOutput("A_vwr_h", 32'(vwr_addr_h), 32'd0);
    checkOutput("A_vwr_v", 32'(vwr_addr_v), 32'd0);
    checkOutput("A_cur_x", 32'(cur_x), 32'd1);
    checkOutput("A_cur_y", 32'(cur_y), 32'd0);
    checkOutput("A_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("A_pulse_end", 32'(vwr_en), 32'd0);

    $display("[TB] full row wrap");
    applyReset();
    wc = writeCount;
    for (int i = 0; i < 70; i++) applyStimulus(8'h41);
    @(negedge clk);
    checkOutput("row_writes", 32'(writeCount - wc), 32'd70);
    checkOutput("row_last_h", 32'(lastH), 32'd69);
    checkOutput("row_last_v", 32'(lastV), 32'd0);
    checkOutput("row_cur_x", 32'(cur_x), 32'd0);
    checkOutput("row_cur_y", 32'(cur_y), 32'd1);

    $display("[TB] backspace cases");
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(8'h0D);
    checkOutput("cr_cur_y", 32'(cur_y), 32'd3);
    applyStimulus(8'h08);
    checkOutput("bs_up_en", 32'(vwr_en), 32'd1);
    checkOutput("bs_up_data", 32'(vwr_data), 32'h00);
    checkOutput("bs_up_h", 32'(vwr_addr_h), 32'd69);
    checkOutput("bs_up_v", 32'(vwr_addr_v), 32'd2);
    checkOutput("bs_up_cur_x", 32'(cur_x), 32'd69);
    checkOutput("bs_up_cur_y", 32'(cur_y), 32'd2);
    applyReset();
    applyStimulus(8'h5A);
    applyStimulus(8'h08);
    checkOutput("bs_left_h", 32'(vwr_addr_h), 32'd0);
    checkOutput("bs_left_data", 32'(vwr_data), 32'h00);
    checkOutput("bs_left_cur_x", 32'(cur_x), 32'd0);
    @(negedge clk);
    wc = writeCount;
    applyStimulus(8'h08);
    checkOutput("bs_origin_en", 32'(vwr_en), 32'd0);
    @(negedge clk);
    checkOutput("bs_origin_writes", 32'(writeCount - wc), 32'd0);
    checkOutput("bs_origin_cur_x", 32'(cur_x), 32'd0);
    checkOutput("bs_origin_cur_y", 32'(cur_y), 32'd0);

    $display("[TB] scroll on enter at bottom row");
    applyReset();
    for (int i = 0; i < 29; i++) applyStimulus(8'h0D);
    for (int i = 0; i < 5; i++) applyStimulus(8'h78);
    checkOutput("pre_cur_x", 32'(cur_x), 32'd5);
    checkOutput("pre_cur_y", 32'(cur_y), 32'd29);
    preloadReq = 1'b1;
    @(negedge clk);
    preloadReq = 1'b0;
    applyStimulus(8'h0D);
    checkOutput("scroll_cur_x", 32'(cur_x), 32'd0);
    checkOutput("scroll_cur_y", 32'(cur_y), 32'd29);
    lowCycles = 0;
    while (!in_ready && lowCycles < 5000) begin
      lowCycles++;
      @(negedge clk);
    end
    checkOutput("scroll_busy_cycles", 32'(lowCycles), 32'd2101);
    @(negedge clk);
    @(negedge clk);
    badCells = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 70; c++)
        if (vram[r][c] !== ((r == 29) ? 8'h00 : 8'(r + 1))) badCells++;
    checkOutput("scroll_bad_cells", 32'(badCells), 32'd0);
    checkOutput("scroll_r0c0", 32'(vram[0][0]), 32'd1);
    checkOutput("scroll_r28c69", 32'(vram[28][69]), 32'd29);
    checkOutput("scroll_r29c35", 32'(vram[29][35]), 32'd0);
    checkOutput("after_cur_x", 32'(cur_x), 32'd0);
    checkOutput("after_cur_y", 32'(cur_y), 32'd29);

    $display("[TB] code held during scroll");
    wc = count42;
    applyStimulus(8'h0D);
    applyStimulus(8'h42);
    @(negedge clk);
    @(negedge clk);
    checkOutput("held_writes", 32'(count42 - wc), 32'd1);
    checkOutput("held_h", 32'(h42), 32'd0);
    checkOutput("held_v", 32'(v42), 32'd29);
    checkOutput("held_vram", 32'(vram[29][0]), 32'h42);
    checkOutput("held_r27", 32'(vram[27][0]), 32'd29);
    checkOutput("held_r28", 32'(vram[28][0]), 32'd0);
    checkOutput("held_cur_x", 32'(cur_x), 32'd1);

    $display("[TB] reset during scroll");
    applyStimulus(8'h0D);
    repeat (499) @(negedge clk);
    checkOutput("mid_scroll_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    wc = writeCount;
    checkOutput("abort_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_vwr_en", 32'(vwr_en), 32'd0);
    checkOutput("abort_cur_x", 32'(cur_x), 32'd0);
    checkOutput("abort_cur_y", 32'(cur_y), 32'd0);
    repeat (200) @(negedge clk);
    checkOutput("abort_no_writes", 32'(writeCount - wc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
